// File: rtl/avalon_aes_master.sv
// avalon_aes_master: Avalon-MM initiator that runs one AES decryption on the
// register-mapped AES slave (key words 0-3, cipher 4-7, plain 8-11, START 14,
// DONE 15) without processor involvement.
// Optional feature macro: AES_TIMEOUT_EN (poll counter + ERR on DONE timeout).
module avalon_aes_master #(
    parameter int POLL_GAP      = 4,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         START,
    input  logic [127:0] KEY,
    input  logic [127:0] CIPHER,
    output logic         BUSY,
    output logic         DONE,
    output logic [127:0] PLAIN,
    output logic         ERR,
    output logic         AVL_CS,
    output logic         AVL_READ,
    output logic         AVL_WRITE,
    output logic [3:0]   AVL_ADDR,
    output logic [3:0]   AVL_BYTE_EN,
    output logic [31:0]  AVL_WRITEDATA,
    input  logic [31:0]  AVL_READDATA,
    input  logic         AVL_WAITREQUEST
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_KEY, S_WR_MSG, S_WR_START, S_POLL,
        S_GAP, S_RD_MSG, S_CLR_START, S_FIN
    } state_t;

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_t         state, state_n;
    logic [1:0]     cnt, cnt_n;
    logic [GW-1:0]  gap_cnt;
    logic [127:0]   key_q, cipher_q, key_src, cipher_src;
    logic           xfer, timeout;
    logic           nxt_rd, nxt_wr;
    logic [3:0]     nxt_addr;
    logic [31:0]    nxt_wdata;

    // A transfer completes in any cycle it is presented without a stall.
    assign xfer = AVL_CS & ~AVL_WAITREQUEST;

`ifdef AES_TIMEOUT_EN
    localparam int PW = $clog2(TIMEOUT_POLLS + 1);
    logic [PW-1:0] poll_cnt;

    assign timeout = (poll_cnt == PW'(TIMEOUT_POLLS - 1));

    // Count completed DONE reads; ERR marks the give-up path until next accept.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            poll_cnt <= '0;
            ERR      <= 1'b0;
        end else if (state == S_IDLE && START) begin
            poll_cnt <= '0;
            ERR      <= 1'b0;
        end else if (state == S_POLL && xfer && AVL_READDATA == 32'h0) begin
            poll_cnt <= poll_cnt + 1'b1;
            if (timeout) ERR <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign ERR     = 1'b0;
`endif

    // State and word counter registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state: phases advance only on completed transfers, so stalls freeze everything.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE:      if (START) begin state_n = S_WR_KEY; cnt_n = 2'd0; end
            S_WR_KEY:    if (xfer) begin cnt_n = cnt + 2'd1; if (cnt == 2'd3) state_n = S_WR_MSG; end
            S_WR_MSG:    if (xfer) begin cnt_n = cnt + 2'd1; if (cnt == 2'd3) state_n = S_WR_START; end
            S_WR_START:  if (xfer) state_n = S_POLL;
            S_POLL: begin
                if (xfer) begin
                    if (AVL_READDATA != 32'h0) state_n = S_RD_MSG;
                    else if (timeout)          state_n = S_CLR_START;
                    else if (POLL_GAP > 0)     state_n = S_GAP;
                end
            end
            S_GAP:       if (gap_cnt == GAP_LAST) state_n = S_POLL;
            S_RD_MSG:    if (xfer) begin cnt_n = cnt + 2'd1; if (cnt == 2'd3) state_n = S_CLR_START; end
            S_CLR_START: if (xfer) state_n = S_FIN;
            S_FIN:       state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    // Bus command for the upcoming cycle, derived from the next state so outputs can be registered.
    always_comb begin
        key_src    = (state == S_IDLE) ? KEY : key_q;
        cipher_src = (state == S_IDLE) ? CIPHER : cipher_q;
        nxt_rd     = 1'b0;
        nxt_wr     = 1'b0;
        nxt_addr   = 4'd0;
        nxt_wdata  = 32'h0;
        case (state_n)
            S_WR_KEY:    begin nxt_wr = 1'b1; nxt_addr = {2'b00, cnt_n}; nxt_wdata = key_src[{~cnt_n, 5'd0} +: 32]; end
            S_WR_MSG:    begin nxt_wr = 1'b1; nxt_addr = {2'b01, cnt_n}; nxt_wdata = cipher_src[{~cnt_n, 5'd0} +: 32]; end
            S_WR_START:  begin nxt_wr = 1'b1; nxt_addr = 4'd14; nxt_wdata = 32'h1; end
            S_POLL:      begin nxt_rd = 1'b1; nxt_addr = 4'd15; end
            S_RD_MSG:    begin nxt_rd = 1'b1; nxt_addr = {2'b10, cnt_n}; end
            S_CLR_START: begin nxt_wr = 1'b1; nxt_addr = 4'd14; nxt_wdata = 32'h0; end
            default:     ;
        endcase
    end

    // Registered Avalon outputs; unchanged during a stall because state/cnt hold.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AVL_CS        <= 1'b0;
            AVL_READ      <= 1'b0;
            AVL_WRITE     <= 1'b0;
            AVL_ADDR      <= 4'd0;
            AVL_BYTE_EN   <= 4'd0;
            AVL_WRITEDATA <= 32'h0;
        end else begin
            AVL_CS        <= nxt_rd | nxt_wr;
            AVL_READ      <= nxt_rd;
            AVL_WRITE     <= nxt_wr;
            AVL_ADDR      <= nxt_addr;
            AVL_BYTE_EN   <= (nxt_rd | nxt_wr) ? 4'hF : 4'h0;
            AVL_WRITEDATA <= nxt_wdata;
        end
    end

    // Operand capture, plaintext assembly, handshake flags and poll-gap timer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_q    <= '0;
            cipher_q <= '0;
            PLAIN    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            DONE    <= (state == S_FIN);
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            if (state == S_IDLE && START) begin
                key_q    <= KEY;
                cipher_q <= CIPHER;
                PLAIN    <= '0;
                BUSY     <= 1'b1;
            end
            if (state == S_RD_MSG && xfer) PLAIN[{~cnt, 5'd0} +: 32] <= AVL_READDATA;
            if (state == S_FIN) BUSY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_avalon_aes_master.sv
// Bench for avalon_aes_master: AES-slave register model, table of directed
// operations, plus hand sequences for latency, poll spacing and async reset.
module tb_avalon_aes_master;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         START = 1'b0;
    logic [127:0] KEY = '0, CIPHER = '0;
    logic         BUSY, DONE, ERR;
    logic [127:0] PLAIN;
    logic         AVL_CS, AVL_READ, AVL_WRITE;
    logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
    logic [31:0]  AVL_WRITEDATA, AVL_READDATA;
    logic         AVL_WAITREQUEST = 1'b0;

    avalon_aes_master #(.POLL_GAP(4), .TIMEOUT_POLLS(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .KEY(KEY), .CIPHER(CIPHER),
        .BUSY(BUSY), .DONE(DONE), .PLAIN(PLAIN), .ERR(ERR),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Slave model: DONE reads nonzero once slave_n polls have been seen since START was set.
    int           slave_n = 0;
    logic [127:0] slave_plain = '0;
    bit           stall_rand = 1'b0;
    int           polls_seen = 0;

    always_comb begin
        AVL_READDATA = 32'h0;
        case (AVL_ADDR)
            4'd8:    AVL_READDATA = slave_plain[127:96];
            4'd9:    AVL_READDATA = slave_plain[95:64];
            4'd10:   AVL_READDATA = slave_plain[63:32];
            4'd11:   AVL_READDATA = slave_plain[31:0];
            4'd15:   AVL_READDATA = (polls_seen >= slave_n) ? 32'h1 : 32'h0;
            default: AVL_READDATA = 32'h0;
        endcase
    end

    always @(posedge CLK) begin
        if (AVL_CS && !AVL_WAITREQUEST) begin
            if (AVL_WRITE && AVL_ADDR == 4'd14 && AVL_WRITEDATA == 32'h1) polls_seen <= 0;
            else if (AVL_READ && AVL_ADDR == 4'd15) polls_seen <= polls_seen + 1;
        end
    end

    always @(posedge CLK) begin
        #1;
        AVL_WAITREQUEST = stall_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    // Monitor: transaction log, stall stability, DONE pulses, BUSY rise time.
    typedef struct { bit we; logic [3:0] addr; logic [31:0] data; int cyc; } tr_t;
    tr_t         tlog[$];
    int          done_cnt = 0, stall_viol = 0, last_done_cyc = 0, busy_rise_cyc = 0;
    bit          prev_stall = 0, prev_busy = 0, prev_done = 0;
    logic [42:0] prev_snap = '0;

    always @(negedge CLK) begin
        logic [42:0] snap;
        tr_t t;
        snap = {AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA};
        if (AVL_CS && !AVL_WAITREQUEST) begin
            t.we = AVL_WRITE; t.addr = AVL_ADDR; t.data = AVL_WRITEDATA; t.cyc = cyc;
            tlog.push_back(t);
        end
        if (prev_stall && snap != prev_snap) stall_viol++;
        prev_stall = AVL_CS && AVL_WAITREQUEST;
        prev_snap  = snap;
        if (DONE) done_cnt++;
        if (DONE && !prev_done) last_done_cyc = cyc;
        if (BUSY && !prev_busy) busy_rise_cyc = cyc;
        prev_done = DONE;
        prev_busy = BUSY;
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [127:0] key, cipher, slave_plain, exp_plain;
        int           n;
        bit           rnd;
        logic         exp_err;
        int           exp_polls;
    } vec_t;

    int           log_base, done_base, viol_base;
    logic [127:0] got_plain;
    logic         got_err;

    // One operation: accept, a stray START while busy, wait (bounded) for DONE.
    task automatic run_op(input vec_t v, output bit to);
        slave_n = v.n; slave_plain = v.slave_plain; stall_rand = v.rnd;
        log_base = tlog.size(); done_base = done_cnt; viol_base = stall_viol;
        @(posedge CLK); #1; KEY = v.key; CIPHER = v.cipher; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0; KEY = ~v.key; CIPHER = ~v.cipher;
        repeat (4) @(posedge CLK);
        #1; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (DONE) begin to = 1'b0; got_plain = PLAIN; got_err = ERR; break; end
        end
        repeat (4) @(posedge CLK);
        #1; stall_rand = 1'b0;
    endtask

    function automatic bit tr_ok(input int idx, input bit we, input int addr, input logic [31:0] data);
        if (idx >= tlog.size()) return 1'b0;
        if (tlog[idx].we != we || tlog[idx].addr != 4'(addr)) return 1'b0;
        if (we && tlog[idx].data !== data) return 1'b0;
        return 1'b1;
    endfunction

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SP_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_C   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] SP_P   = 128'h6bc1bee22e409f96e93d7e117393172a;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        bit   to;
        vecs.push_back('{FIPS_K, FIPS_C, FIPS_P, FIPS_P, 0, 1'b0, 1'b0, 1});
        vecs.push_back('{FIPS_K, FIPS_C, FIPS_P, FIPS_P, 3, 1'b0, 1'b0, 4});
`ifdef AES_TIMEOUT_EN
        vecs.push_back('{FIPS_K, FIPS_C, FIPS_P, 128'h0, 100000, 1'b0, 1'b1, 8});
`endif
        vecs.push_back('{FIPS_K, FIPS_C, FIPS_P, FIPS_P, 2, 1'b1, 1'b0, 3});
        vecs.push_back('{SP_K, SP_C, SP_P, SP_P, 1, 1'b1, 1'b0, 2});

        // Reset state
        #12;
        check("reset_outputs",
              {BUSY, DONE, PLAIN, ERR, AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA},
              '0);
        @(posedge CLK); #1; RESET_N = 1'b1;
        repeat (2) @(posedge CLK);

        foreach (vecs[r]) begin
            int  exp_len, idx, npoll, rd_first, gap_bad;
            bit  seq_ok;
            v = vecs[r];
            run_op(v, to);
            check($sformatf("done_seen[%0d]", r), to, 1'b0);
            check($sformatf("plain[%0d]", r), got_plain, v.exp_plain);
            check($sformatf("err[%0d]", r), got_err, v.exp_err);
            check($sformatf("done_pulses[%0d]", r), done_cnt - done_base, 1);
            check($sformatf("busy_idle[%0d]", r), BUSY, 1'b0);
            check($sformatf("stall_stable[%0d]", r), stall_viol - viol_base, 0);

            exp_len = 9 + v.exp_polls + (v.exp_err ? 0 : 4) + 1;
            seq_ok  = (tlog.size() - log_base) == exp_len;
            idx = log_base;
            for (int i = 0; i < 4; i++) seq_ok &= tr_ok(idx++, 1'b1, i, v.key[127 - 32*i -: 32]);
            for (int i = 0; i < 4; i++) seq_ok &= tr_ok(idx++, 1'b1, 4 + i, v.cipher[127 - 32*i -: 32]);
            seq_ok &= tr_ok(idx++, 1'b1, 14, 32'h1);
            for (int i = 0; i < v.exp_polls; i++) seq_ok &= tr_ok(idx++, 1'b0, 15, 32'h0);
            if (!v.exp_err) for (int i = 0; i < 4; i++) seq_ok &= tr_ok(idx++, 1'b0, 8 + i, 32'h0);
            seq_ok &= tr_ok(idx, 1'b1, 14, 32'h0);
            check($sformatf("bus_sequence[%0d] len=%0d", r, tlog.size() - log_base), seq_ok, 1'b1);

            npoll = 0; rd_first = -1; gap_bad = 0;
            for (int i = log_base; i < tlog.size(); i++) begin
                if (!tlog[i].we && tlog[i].addr == 4'd15) begin
                    if (rd_first >= 0 && tlog[i].cyc - rd_first != 5) gap_bad++;
                    rd_first = tlog[i].cyc;
                    npoll++;
                end
            end
            check($sformatf("poll_count[%0d]", r), npoll, v.exp_polls);
            if (!v.rnd && v.n > 0) check($sformatf("poll_gap[%0d]", r), gap_bad, 0);
            if (!v.rnd && v.n == 0) check($sformatf("latency[%0d]", r), last_done_cyc - busy_rise_cyc, 16);
        end

        // Async reset in the middle of polling, then a normal operation.
        slave_n = 100000; slave_plain = FIPS_P;
        @(posedge CLK); #1; KEY = FIPS_K; CIPHER = FIPS_C; START = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (AVL_READ && AVL_ADDR == 4'd15) begin to = 1'b0; break; end
        end
        check("reach_poll", to, 1'b0);
        #2; RESET_N = 1'b0;
        #1;
        check("async_reset_outputs",
              {BUSY, DONE, PLAIN, ERR, AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA},
              '0);
        @(posedge CLK); #1; RESET_N = 1'b1;
        v = '{FIPS_K, FIPS_C, FIPS_P, FIPS_P, 0, 1'b0, 1'b0, 1};
        run_op(v, to);
        check("post_reset_done", to, 1'b0);
        check("post_reset_plain", got_plain, FIPS_P);
        check("post_reset_err", got_err, 1'b0);
        check("post_reset_latency", last_done_cyc - busy_rise_cyc, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
